pmod1553_phy: RTL and testbench
===============================

# pmod1553_phy

Parametrised, multi-channel physical-layer controller between the 1553 encoder/decoder cores and PMOD 1553 transceiver pins (pin1/pin2 receive legs, pin3/pin4 transmit legs, pin5 driver enable). Per channel it synchronises and deglitches the receive legs and detects bus activity. It also sequences the transmit driver: enable guard, drive, drain, and a babble watchdog. It replaces direct pin wiring at the system top and scales from one PMOD to CHANNELS PMODs.

## Interface
- CHANNELS, 1, number of independent PMOD 1553 channels
- FILTER_LEN, 3, consecutive identical synchronised samples required to update a filtered rx leg (1..15)
- IDLE_CYCLES, 48, cycles without filtered rx transition before rx_active drops (4 us at 12 MHz)
- GUARD_CYCLES, 6, driver-enable settle time and drain time in cycles
- MAX_TX_CYCLES, 9600, watchdog limit for continuous ACTIVE state (800 us at 12 MHz)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_p_pin  in  CHANNELS  PMOD pin1 per channel
- rx_n_pin  in  CHANNELS  PMOD pin2 per channel
- tx_p_pin  out  CHANNELS  PMOD pin3 per channel
- tx_n_pin  out  CHANNELS  PMOD pin4 per channel
- tx_en_pin  out  CHANNELS  PMOD pin5, driver enable, active-high
- rx_diff  out  2*CHANNELS  filtered {p,n} per channel, channel c at [2c+1:2c]
- rx_active  out  CHANNELS  bus activity per channel
- tx_diff  in  2*CHANNELS  requested {p,n} drive per channel
- tx_req  in  CHANNELS  transmit request, level, per channel
- tx_ready  out  CHANNELS  high while tx_diff is passed to pins
- tx_fault  out  CHANNELS  watchdog tripped, sticky until tx_req drops
- loopback  in  1  internal loopback select; used only with PMOD1553_LOOPBACK_EN

## Operation
- Channels are fully independent and have identical logic.
- RX sync: two flops per leg. Filter: per-leg counter. The filtered leg takes the synchronised value after FILTER_LEN consecutive equal samples that differ from the current output. Any disagreement restarts the count.
- rx_active: a down-counter reloads to IDLE_CYCLES on any filtered-leg change and decrements to 0. rx_active = (count != 0).
- TX FSM states:
  - IDLE: en=0, pins 00. tx_req=1 and rx_active=0 → ENABLE. A request while rx_active=1 is held off; the FSM stays in IDLE until the bus is idle.
  - ENABLE: en=1, pins 00, counts GUARD_CYCLES → ACTIVE.
  - ACTIVE: en=1, tx_ready=1, pins = registered tx_diff. tx_req=0 → DRAIN. MAX_TX_CYCLES consecutive cycles → FAULT.
  - DRAIN: en=1, pins 00, counts GUARD_CYCLES → IDLE. A tx_req reasserted during DRAIN is ignored until IDLE.
  - FAULT: en=0, pins 00, tx_fault=1. tx_req=0 → IDLE.
- Illegal drive: tx_diff=11 in ACTIVE drives pins 00. Both legs are never driven high simultaneously.
- Reset values: tx_p/n_pin=0, tx_en_pin=0, rx_diff=0, rx_active=0, tx_ready=0, tx_fault=0, FSM=IDLE, all counters 0. Reset mid-transmit drops en and pins asynchronously.

## Timing
- rx pin → rx_diff: 2 sync cycles + FILTER_LEN cycles (5 at default).
- rx_diff change → rx_active high: next cycle. Last change → rx_active low: IDLE_CYCLES cycles later.
- tx_req rise (bus idle) → tx_en_pin high: 1 cycle. tx_ready high: GUARD_CYCLES+1 cycles after tx_req rise.
- tx_diff → pins: 1 cycle registered, valid only while tx_ready=1.
- tx_req fall → tx_ready low: 1 cycle. tx_en_pin low: GUARD_CYCLES+1 cycles after tx_req fall.
- Watchdog: tx_fault rises on cycle MAX_TX_CYCLES of ACTIVE. tx_en_pin falls in the same cycle.
- All outputs are registered.

## Configuration
- PMOD1553_LOOPBACK_EN defined:
  - loopback=1 feeds each channel's RX synchronisers from its own registered tx_p/tx_n (pre-pin) values.
  - tx_en_pin is forced 0 and tx_p/n_pin are forced 0, so the bus is never driven.
  - The FSM runs normally, and the rx_active hold-off is ignored for that channel.
- PMOD1553_LOOPBACK_EN undefined: the loopback input is ignored, and no mux is synthesised.

## Test plan
- Reset mid-ACTIVE with tx_diff=10 → tx_en_pin, tx_p_pin drop to 0 immediately; all outputs at reset values.
- Glitch: rx_p_pin high for 2 cycles, FILTER_LEN=3 → rx_diff unchanged. High for 3 cycles → rx_diff[1]=1 at cycle 5, rx_active=1, falls 48 cycles after last change.
- Transmit: tx_req=1 on an idle bus → tx_en_pin=1 after 1 cycle, tx_ready=1 after 7. Drive 10,01 → pins follow with 1-cycle lag. tx_req=0 → pins 00, en low 7 cycles later.
- Hold-off: tx_req=1 while rx_active=1 → tx_en_pin stays 0 until rx_active falls, then ENABLE.
- Watchdog, MAX_TX_CYCLES=100: hold tx_req → tx_fault=1, tx_en_pin=0 at ACTIVE cycle 100. Drop tx_req → tx_fault=0, IDLE. tx_diff=11 → pins 00.
- CHANNELS=2, PMOD1553_LOOPBACK_EN, loopback=1: channel 0 transmits 10 → rx_diff[1:0]=10 after 5 cycles, tx_en_pin=00, channel 1 unaffected.

Source files
------------

// File: rtl/pmod1553_phy.sv
// pmod1553_phy: per-channel RX synchronise/deglitch/activity detect and TX driver sequencing for PMOD 1553 transceivers.
// Build option PMOD1553_LOOPBACK_EN: internal TX->RX loopback selected by the loopback input, bus never driven.
module pmod1553_phy #(
   parameter int CHANNELS      = 1,
   parameter int FILTER_LEN    = 3,
   parameter int IDLE_CYCLES   = 48,
   parameter int GUARD_CYCLES  = 6,
   parameter int MAX_TX_CYCLES = 9600
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CHANNELS-1:0]   rx_p_pin,
   input  logic [CHANNELS-1:0]   rx_n_pin,
   output logic [CHANNELS-1:0]   tx_p_pin,
   output logic [CHANNELS-1:0]   tx_n_pin,
   output logic [CHANNELS-1:0]   tx_en_pin,
   output logic [2*CHANNELS-1:0] rx_diff,
   output logic [CHANNELS-1:0]   rx_active,
   input  logic [2*CHANNELS-1:0] tx_diff,
   input  logic [CHANNELS-1:0]   tx_req,
   output logic [CHANNELS-1:0]   tx_ready,
   output logic [CHANNELS-1:0]   tx_fault,
   input  logic                  loopback,
   output logic [3*CHANNELS-1:0] dbg_tx_state
);

   localparam int FCW  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int ACW  = $clog2(IDLE_CYCLES + 1);
   localparam int TMAX = (MAX_TX_CYCLES > GUARD_CYCLES) ? MAX_TX_CYCLES : GUARD_CYCLES;
   localparam int TCW  = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ENABLE = 3'd1,
      ST_ACTIVE = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_FAULT  = 3'd4
   } tx_state_t;

`ifndef PMOD1553_LOOPBACK_EN
   logic unused_loopback;
   assign unused_loopback = loopback;
`endif

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [1:0]          rx_raw, sync1, sync2, filt, upd;
      logic [1:0][FCW-1:0] fcnt;
      logic [ACW-1:0]      act_cnt;
      logic                act_q, busy;
      tx_state_t           state, state_nx;
      logic [TCW-1:0]      cnt, cnt_nx;
      logic [1:0]          drv_q, drv_nx;
      logic                en_nx;

`ifdef PMOD1553_LOOPBACK_EN
      assign rx_raw = loopback ? drv_q : {rx_p_pin[c], rx_n_pin[c]};
      assign busy   = act_q & ~loopback;
`else
      assign rx_raw = {rx_p_pin[c], rx_n_pin[c]};
      assign busy   = act_q;
`endif

      // A leg updates on the FILTER_LEN-th consecutive synchronised sample that differs from its output.
      always_comb begin
         for (int l = 0; l < 2; l++)
            upd[l] = (sync2[l] != filt[l]) && (fcnt[l] == FCW'(FILTER_LEN - 1));
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            filt    <= '0;
            fcnt    <= '0;
            act_cnt <= '0;
            act_q   <= 1'b0;
         end else begin
            sync1 <= rx_raw;
            sync2 <= sync1;
            for (int l = 0; l < 2; l++) begin
               if (sync2[l] == filt[l]) begin
                  fcnt[l] <= '0;
               end else if (upd[l]) begin
                  filt[l] <= sync2[l];
                  fcnt[l] <= '0;
               end else begin
                  fcnt[l] <= fcnt[l] + 1'b1;
               end
            end
            if (|upd)
               act_cnt <= ACW'(IDLE_CYCLES);
            else if (act_cnt != '0)
               act_cnt <= act_cnt - 1'b1;
            // Registered one cycle behind the reload; drops exactly IDLE_CYCLES after the last change.
            act_q <= (act_cnt > ACW'(1));
         end
      end

      // tx_ready=1 means the tx_diff present at this edge reaches the pins on the next edge; no back-pressure.
      always_comb begin
         state_nx = state;
         cnt_nx   = cnt + 1'b1;
         unique case (state)
            ST_IDLE: begin
               cnt_nx = '0;
               if (tx_req[c] && !busy) state_nx = ST_ENABLE;
            end
            ST_ENABLE: begin
               if (cnt == TCW'(GUARD_CYCLES - 1)) begin
                  state_nx = ST_ACTIVE;
                  cnt_nx   = '0;
               end
            end
            ST_ACTIVE: begin
               if (!tx_req[c]) begin
                  state_nx = ST_DRAIN;
                  cnt_nx   = '0;
               end else if (cnt == TCW'(MAX_TX_CYCLES - 1)) begin
                  state_nx = ST_FAULT;
                  cnt_nx   = '0;
               end
            end
            ST_DRAIN: begin
               if (cnt == TCW'(GUARD_CYCLES - 1)) begin
                  state_nx = ST_IDLE;
                  cnt_nx   = '0;
               end
            end
            ST_FAULT: begin
               cnt_nx = '0;
               if (!tx_req[c]) state_nx = ST_IDLE;
            end
            default: begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end
         endcase
         en_nx  = (state_nx == ST_ENABLE) || (state_nx == ST_ACTIVE) || (state_nx == ST_DRAIN);
         drv_nx = 2'b00;
         if (state_nx == ST_ACTIVE && tx_diff[2*c +: 2] != 2'b11)
            drv_nx = tx_diff[2*c +: 2];
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            drv_q        <= 2'b00;
            tx_ready[c]  <= 1'b0;
            tx_fault[c]  <= 1'b0;
         end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            drv_q        <= drv_nx;
            tx_ready[c]  <= (state_nx == ST_ACTIVE);
            tx_fault[c]  <= (state_nx == ST_FAULT);
         end
      end

`ifdef PMOD1553_LOOPBACK_EN
      // Separate pin registers so loopback can keep the bus quiet while drv_q still feeds RX.
      logic [1:0] pin_q;
      logic       pin_en_q;
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            pin_q    <= 2'b00;
            pin_en_q <= 1'b0;
         end else begin
            pin_q    <= loopback ? 2'b00 : drv_nx;
            pin_en_q <= en_nx & ~loopback;
         end
      end
      assign tx_p_pin[c]  = pin_q[1];
      assign tx_n_pin[c]  = pin_q[0];
      assign tx_en_pin[c] = pin_en_q;
`else
      logic en_q;
      always_ff @(posedge clk or posedge reset) begin
         if (reset) en_q <= 1'b0;
         else       en_q <= en_nx;
      end
      assign tx_p_pin[c]  = drv_q[1];
      assign tx_n_pin[c]  = drv_q[0];
      assign tx_en_pin[c] = en_q;
`endif

      assign rx_diff[2*c +: 2]      = filt;
      assign rx_active[c]           = act_q;
      assign dbg_tx_state[3*c +: 3] = state;
   end

endmodule

// File: tb/tb_pmod1553_phy.sv
// Bench for pmod1553_phy with two channels and a short watchdog; loopback section follows PMOD1553_LOOPBACK_EN.
module tb_pmod1553_phy;

   localparam int CH = 2;
   localparam int FL = 3;
   localparam int IC = 48;
   localparam int GC = 6;
   localparam int MT = 100;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ENABLE = 3'd1;
   localparam logic [2:0] S_ACTIVE = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_FAULT  = 3'd4;

   // clock / reset
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [CH-1:0]   rx_p_pin, rx_n_pin, tx_p_pin, tx_n_pin, tx_en_pin;
   logic [2*CH-1:0] rx_diff, tx_diff;
   logic [CH-1:0]   rx_active, tx_req, tx_ready, tx_fault;
   logic            loopback;
   logic [3*CH-1:0] dbg_tx_state;

   pmod1553_phy #(
      .CHANNELS(CH), .FILTER_LEN(FL), .IDLE_CYCLES(IC),
      .GUARD_CYCLES(GC), .MAX_TX_CYCLES(MT)
   ) dut (
      .clk(clk), .reset(reset),
      .rx_p_pin(rx_p_pin), .rx_n_pin(rx_n_pin),
      .tx_p_pin(tx_p_pin), .tx_n_pin(tx_n_pin), .tx_en_pin(tx_en_pin),
      .rx_diff(rx_diff), .rx_active(rx_active),
      .tx_diff(tx_diff), .tx_req(tx_req),
      .tx_ready(tx_ready), .tx_fault(tx_fault),
      .loopback(loopback), .dbg_tx_state(dbg_tx_state)
   );

   // scoreboard
   typedef struct {
      logic [1:0] drive;
      logic [1:0] pins;
   } vec_t;
   vec_t       vecs [8];
   logic [5:0] exp_q [$];
   int         n_vec  = 0;
   int         n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      rx_p_pin = '0;
      rx_n_pin = '0;
      tx_diff  = '0;
      tx_req   = '0;
      loopback = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      tick(3);
      reset = 1'b0;
      tick(1);
   endtask

   function automatic logic [5:0] pin_word();
      return {tx_en_pin[1], tx_p_pin[1], tx_n_pin[1], tx_en_pin[0], tx_p_pin[0], tx_n_pin[0]};
   endfunction

   initial begin
      logic [1:0] d;
      vecs[0] = '{2'b10, 2'b10};
      vecs[1] = '{2'b01, 2'b01};
      vecs[2] = '{2'b11, 2'b00};
      vecs[3] = '{2'b00, 2'b00};
      vecs[4] = '{2'b10, 2'b10};
      vecs[5] = '{2'b11, 2'b00};
      vecs[6] = '{2'b01, 2'b01};
      vecs[7] = '{2'b10, 2'b10};

      // reset values
      do_reset();
      check("rst_tx_en", 32'(tx_en_pin), 0);
      check("rst_pins", 32'({tx_p_pin, tx_n_pin}), 0);
      check("rst_rx_diff", 32'(rx_diff), 0);
      check("rst_rx_active", 32'(rx_active), 0);
      check("rst_ready_fault", 32'({tx_ready, tx_fault}), 0);
      check("rst_state", 32'(dbg_tx_state), 0);

      // two-cycle glitch is rejected
      rx_p_pin[0] = 1'b1;
      tick(2);
      rx_p_pin[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("glitch_rx_diff", 32'(rx_diff), 0);
         check("glitch_rx_active", 32'(rx_active), 0);
      end

      // three-cycle pulse passes, then its trailing edge passes too
      rx_p_pin[0] = 1'b1;
      tick(3);
      rx_p_pin[0] = 1'b0;
      tick(1); check("filt_edge4", 32'(rx_diff), 0);
      tick(1); check("filt_edge5", 32'(rx_diff), 32'h2);
      check("act_edge5", 32'(rx_active), 0);
      tick(1); check("act_edge6", 32'(rx_active), 32'h1);
      tick(1); check("filt_edge7", 32'(rx_diff), 32'h2);
      tick(1); check("filt_edge8", 32'(rx_diff), 0);
      tick(IC - 1); check("act_hold", 32'(rx_active), 32'h1);
      tick(1); check("act_drop", 32'(rx_active), 0);

      // transmit on channel 0
      tx_req[0] = 1'b1;
      tick(1);
      check("en_rise", 32'(tx_en_pin), 32'h1);
      check("state_enable", 32'(dbg_tx_state), 32'(S_ENABLE));
      tick(GC - 1); check("ready_pre", 32'(tx_ready), 0);
      tick(1); check("ready_rise", 32'(tx_ready), 32'h1);
      check("state_active", 32'(dbg_tx_state), 32'(S_ACTIVE));

      for (int i = 0; i < 8; i++) begin
         tx_diff[1:0] = vecs[i].drive;
         tx_diff[3:2] = 2'($urandom_range(0, 3));
         exp_q.push_back({3'b000, 1'b1, vecs[i].pins});
         tick(1);
         check("tx_pins_vec", 32'(pin_word()), 32'(exp_q.pop_front()));
         check("tx_ready_hold", 32'(tx_ready), 32'h1);
      end
      for (int i = 0; i < 16; i++) begin
         d = 2'($urandom_range(0, 3));
         tx_diff[1:0] = d;
         tx_diff[3:2] = 2'($urandom_range(0, 3));
         exp_q.push_back({3'b000, 1'b1, (d == 2'b11) ? 2'b00 : d});
         tick(1);
         check("tx_pins_rand", 32'(pin_word()), 32'(exp_q.pop_front()));
      end

      // drain; a request reasserted during drain waits for idle
      tx_diff = 4'b0010;
      tx_req[0] = 1'b0;
      tick(1);
      check("drain_ready", 32'(tx_ready), 0);
      check("drain_pins", 32'(pin_word()), 32'b000_100);
      check("state_drain", 32'(dbg_tx_state), 32'(S_DRAIN));
      tx_req[0] = 1'b1;
      tick(GC - 1); check("drain_en_hold", 32'(tx_en_pin), 32'h1);
      tick(1); check("drain_en_drop", 32'(tx_en_pin), 0);
      check("state_idle", 32'(dbg_tx_state), 32'(S_IDLE));
      tick(1); check("reenable", 32'(tx_en_pin), 32'h1);

      // watchdog
      tick(GC); check("wd_ready", 32'(tx_ready), 32'h1);
      tick(MT - 1);
      check("wd_pre_fault", 32'(tx_fault), 0);
      check("wd_pre_pins", 32'(pin_word()), 32'b000_110);
      tick(1);
      check("wd_fault", 32'(tx_fault), 32'h1);
      check("wd_en_drop", 32'(pin_word()), 0);
      check("wd_ready_drop", 32'(tx_ready), 0);
      check("state_fault", 32'(dbg_tx_state), 32'(S_FAULT));
      tick(3); check("wd_sticky", 32'(tx_fault), 32'h1);
      tx_req[0] = 1'b0;
      tick(1);
      check("wd_clear", 32'(tx_fault), 0);
      check("wd_idle", 32'(dbg_tx_state), 32'(S_IDLE));

      // hold-off while the bus is active
      rx_p_pin[0] = 1'b1;
      tick(6); check("holdoff_busy", 32'(rx_active), 32'h1);
      tx_req[0] = 1'b1;
      tick(40); check("holdoff_en", 32'(tx_en_pin), 0);
      tick(7);
      check("holdoff_quiet", 32'(rx_active), 0);
      check("holdoff_en_late", 32'(tx_en_pin), 0);
      tick(1); check("holdoff_release", 32'(tx_en_pin), 32'h1);

      // asynchronous reset mid-ACTIVE
      tick(GC);
      check("pre_rst_pins", 32'(pin_word()), 32'b000_110);
      #2 reset = 1'b1;
      #1;
      check("arst_pins", 32'(pin_word()), 0);
      check("arst_rx_diff", 32'(rx_diff), 0);
      check("arst_flags", 32'({rx_active, tx_ready, tx_fault}), 0);
      check("arst_state", 32'(dbg_tx_state), 0);
      clear_inputs();
      tick(2);
      reset = 1'b0;
      tick(1);

      // channel 1 n leg, channel 0 untouched
      rx_n_pin[1] = 1'b1;
      tick(4); check("ch1_rx_pre", 32'(rx_diff), 0);
      tick(1); check("ch1_rx", 32'(rx_diff), 32'h4);
      tick(1); check("ch1_active", 32'(rx_active), 32'h2);

`ifdef PMOD1553_LOOPBACK_EN
      loopback = 1'b1;
      tx_diff[1:0] = 2'b10;
      tx_req[0] = 1'b1;
      tick(1);
      check("lb_en_forced", 32'(tx_en_pin), 0);
      check("lb_state", 32'(dbg_tx_state[2:0]), 32'(S_ENABLE));
      tick(GC);
      check("lb_ready", 32'(tx_ready[0]), 32'h1);
      check("lb_pins", 32'(pin_word()), 0);
      tick(4); check("lb_rx_pre", 32'(rx_diff[1:0]), 0);
      tick(1);
      check("lb_rx", 32'(rx_diff[1:0]), 32'h2);
      check("lb_ch1", 32'(rx_diff[3:2]), 32'h1);
      check("lb_en_still", 32'(tx_en_pin), 0);
`else
      loopback = 1'b1;
      tx_diff[1:0] = 2'b10;
      tx_req[0] = 1'b1;
      tick(1); check("lb_ignored_en", 32'(tx_en_pin), 32'h1);
      tick(GC); check("lb_ignored_pins", 32'(pin_word()), 32'b000_110);
      tick(5); check("lb_ignored_rx", 32'(rx_diff), 32'h4);
`endif

      check("sb_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
